// File: rtl/multiplicador_booth_if.sv
// Request/result bundle for the sequential Booth multiplier.
// Ports (slave = multiplier side):
//   start         : operation request, sampled in IDLE
//   multiplicando : signed 32-bit multiplicand
//   multiplicador : signed 32-bit multiplier
//   hi / lo       : registered 64-bit product halves
//   fim           : one-cycle completion pulse
//   ocupado       : busy while the Booth iterations run
interface multiplicador_booth_if;
    logic        start;
    logic [31:0] multiplicando;
    logic [31:0] multiplicador;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        fim;
    logic        ocupado;

    modport master (
        output start, multiplicando, multiplicador,
        input  hi, lo, fim, ocupado
    );

    modport slave (
        input  start, multiplicando, multiplicador,
        output hi, lo, fim, ocupado
    );
endinterface

// File: rtl/multiplicador_booth.sv
// Sequential 32x32 signed multiplier, radix-2 Booth, one step per clock.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : multiplicador_booth_if.slave (start/operands in, hi/lo/fim/ocupado out)
module multiplicador_booth (
    input  logic                      clock,
    input  logic                      reset,
    multiplicador_booth_if.slave      bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned AW = W + 1;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] a, a_next, m, m_next, a_sum;
    logic [W-1:0]  q, q_next;
    logic          qm1, qm1_next;
    logic [CW-1:0] cont, cont_next;
    logic [W-1:0]  hi, hi_next, lo, lo_next;
    logic          fim, fim_next, ocupado, ocupado_next;

    // Booth add/subtract; 33-bit accumulator absorbs -M when M = 0x80000000
    always_comb begin
        unique case ({q[0], qm1})
            2'b01:   a_sum = a + m;
            2'b10:   a_sum = a - m;
            default: a_sum = a;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath/output next values
    always_comb begin
        state_next   = state;
        a_next       = a;
        q_next       = q;
        qm1_next     = qm1;
        m_next       = m;
        cont_next    = cont;
        hi_next      = hi;
        lo_next      = lo;
        fim_next     = 1'b0;
        ocupado_next = ocupado;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    a_next       = '0;
                    q_next       = bus.multiplicador;
                    qm1_next     = 1'b0;
                    m_next       = {bus.multiplicando[W-1], bus.multiplicando};
                    cont_next    = CW'(W - 1);
                    ocupado_next = 1'b1;
                    state_next   = RUN;
                end
            end
            RUN: begin
                // Arithmetic right shift of {A', Q, Qm1}
                a_next   = {a_sum[AW-1], a_sum[AW-1:1]};
                q_next   = {a_sum[0], q[W-1:1]};
                qm1_next = q[0];
                if (cont == '0) begin
                    hi_next      = a_next[W-1:0];
                    lo_next      = q_next;
                    fim_next     = 1'b1;
                    ocupado_next = 1'b0;
                    state_next   = DONE;
                end else begin
                    cont_next = cont - CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            m       <= '0;
            cont    <= '0;
            hi      <= '0;
            lo      <= '0;
            fim     <= 1'b0;
            ocupado <= 1'b0;
        end else begin
            a       <= a_next;
            q       <= q_next;
            qm1     <= qm1_next;
            m       <= m_next;
            cont    <= cont_next;
            hi      <= hi_next;
            lo      <= lo_next;
            fim     <= fim_next;
            ocupado <= ocupado_next;
        end
    end

    assign bus.hi      = hi;
    assign bus.lo      = lo;
    assign bus.fim     = fim;
    assign bus.ocupado = ocupado;
endmodule

// File: tb/tb_multiplicador_booth.sv
// Directed bench for multiplicador_booth: hand-computed products, latency,
// busy/done timing, start-ignored-while-busy, mid-run reset, back-to-back starts.
module tb_multiplicador_booth;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    logic [63:0] last_prod;

    multiplicador_booth_if bus ();

    multiplicador_booth dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    // One multiply: accept, 32 Booth edges, completion, return to IDLE.
    // With disturb set, operands change every RUN cycle and start pulses at RUN cycles 5 and 20.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit disturb);
        @(negedge clock);
        bus.multiplicando = a;
        bus.multiplicador = b;
        bus.start         = 1'b1;
        @(posedge clock); #1;
        check("accept_ocupado", 64'(bus.ocupado), 64'd1);
        check("accept_fim", 64'(bus.fim), 64'd0);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clock);
            bus.start = disturb && (i == 5 || i == 20);
            if (disturb) begin
                bus.multiplicando = $urandom;
                bus.multiplicador = $urandom;
            end
            @(posedge clock); #1;
            if (i < 32) begin
                check("run_ocupado", 64'(bus.ocupado), 64'd1);
                check("run_fim", 64'(bus.fim), 64'd0);
                check("run_hold", {bus.hi, bus.lo}, last_prod);
            end else begin
                check("done_fim", 64'(bus.fim), 64'd1);
                check("done_ocupado", 64'(bus.ocupado), 64'd0);
                check("product", {bus.hi, bus.lo}, exp);
            end
        end
        last_prod = exp;
        @(negedge clock);
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("after_fim", 64'(bus.fim), 64'd0);
        check("after_ocupado", 64'(bus.ocupado), 64'd0);
        check("after_hold", {bus.hi, bus.lo}, last_prod);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_prod = 64'd0;
        bus.start = 1'b0;
        bus.multiplicando = '0;
        bus.multiplicador = '0;
        reset = 1'b1;
        #1;
        check("reset_prod", {bus.hi, bus.lo}, 64'd0);
        check("reset_fim", 64'(bus.fim), 64'd0);
        check("reset_ocupado", 64'(bus.ocupado), 64'd0);
        // start asserted during reset must be ignored
        bus.start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_start_ocupado", 64'(bus.ocupado), 64'd0);
        @(negedge clock);
        bus.start = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_ocupado", 64'(bus.ocupado), 64'd0);

        run_mul(32'd3, 32'd5, 64'h00000000_0000000F, 1'b0);
        run_mul(32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, 1'b0);
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0);
        run_mul(32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        run_mul(32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, 1'b0);
        run_mul(32'd100, 32'd200, 64'h00000000_00004E20, 1'b1);

        // Reset at RUN cycle 10 aborts and clears everything
        @(negedge clock);
        bus.multiplicando = 32'h1234;
        bus.multiplicador = 32'h5678;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_prod", {bus.hi, bus.lo}, 64'd0);
        check("abort_fim", 64'(bus.fim), 64'd0);
        check("abort_ocupado", 64'(bus.ocupado), 64'd0);
        last_prod = 64'd0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            check("post_abort_fim", 64'(bus.fim), 64'd0);
        end
        check("post_abort_ocupado", 64'(bus.ocupado), 64'd0);
        run_mul(32'd12, 32'd12, 64'h00000000_00000090, 1'b0);

        // start held high: completions every 34 cycles
        @(negedge clock);
        bus.multiplicando = 32'd2;
        bus.multiplicador = 32'd3;
        bus.start = 1'b1;
        for (int k = 0; k <= 105; k++) begin
            @(posedge clock); #1;
            if (k == 32 || k == 66 || k == 100) begin
                check("stream_fim", 64'(bus.fim), 64'd1);
                last_prod = 64'd6;
            end else begin
                check("stream_fim", 64'(bus.fim), 64'd0);
            end
            check("stream_prod", {bus.hi, bus.lo}, last_prod);
        end
        @(negedge clock);
        bus.start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
